// File: rtl/shop_ledger_if.sv
// rtl/shop_ledger_if.sv - request/status bundle between the button front end and the ledger core
interface shop_ledger_if #(
    parameter int W_W = 4,
    parameter int W_P = 4,
    parameter int W_S = 16,
    parameter int W_T = 8
);
    logic               cal;
    logic               undo;
    logic [W_W-1:0]     weight;
    logic [W_P-1:0]     per;
    logic [W_W+W_P-1:0] price;
    logic [W_T-1:0]     times;
    logic [W_S-1:0]     sum;
    logic               state_cal;
    logic               state_reset;
    logic               busy;
    logic               full;
    logic               sat;
    logic               err;

    modport master (
        output cal, undo, weight, per,
        input  price, times, sum, state_cal, state_reset, busy, full, sat, err
    );

    modport slave (
        input  cal, undo, weight, per,
        output price, times, sum, state_cal, state_reset, busy, full, sat, err
    );
endinterface

// File: rtl/shop_ledger.sv
// rtl/shop_ledger.sv - shift-add price multiplier, saturating running sum and undo history stack
module shop_ledger #(
    parameter int W_W   = 4,
    parameter int W_P   = 4,
    parameter int W_S   = 16,
    parameter int DEPTH = 8,
    parameter int W_T   = 8
) (
    input  logic           clk100mhz,
    input  logic           reset,
    shop_ledger_if.slave   bus
);
    localparam int W_M = W_W + W_P;
    localparam int W_C = $clog2(W_W + 1);
    localparam int W_X = W_S + 1;

    typedef enum logic [1:0] {IDLE, MUL, ADD, UNDO} state_t;

    state_t         state_q, state_d;
    logic [W_W-1:0] mplier_q, mplier_d;
    logic [W_M-1:0] mcand_q, mcand_d;
    logic [W_M-1:0] prod_q, prod_d;
    logic [W_C-1:0] cnt_q, cnt_d;
    logic [W_T-1:0] times_q, times_d;
    logic [W_S-1:0] sum_q, sum_d;
    logic           sat_q, sat_d;
    logic           scal_q, scal_d;
    logic           sres_q, sres_d;
    logic           err_q, err_d;
    logic [W_M-1:0] stack_q [DEPTH];
    logic           push;
    logic [W_M-1:0] top;
    logic           full;
    logic [W_S:0]   sum_ext;

    assign full    = (times_q == W_T'(DEPTH));
    assign sum_ext = {1'b0, sum_q} + W_X'(prod_q);

    // Top of stack is the entry just below the item count; empty ledger reads as 0.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (times_q == W_T'(i + 1)) begin
                top = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        times_d  = times_q;
        sum_d    = sum_q;
        sat_d    = sat_q;
        scal_d   = scal_q;
        sres_d   = sres_q;
        err_d    = 1'b0;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cal && bus.undo) begin
                    err_d = 1'b1;
                end else if (bus.cal) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        mplier_d = bus.weight;
                        mcand_d  = W_M'(bus.per);
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end
                end else if (bus.undo) begin
                    if (times_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = UNDO;
                    end
                end
            end
            MUL: begin
                err_d    = bus.cal | bus.undo;
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == W_C'(W_W - 1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                err_d   = bus.cal | bus.undo;
                push    = 1'b1;
                times_d = times_q + 1'b1;
                if (sum_ext[W_S]) begin
                    sum_d = '1;
                    sat_d = 1'b1;
                end else begin
                    sum_d = sum_ext[W_S-1:0];
                end
                scal_d  = 1'b1;
                sres_d  = 1'b0;
                state_d = IDLE;
            end
            UNDO: begin
                err_d   = bus.cal | bus.undo;
                times_d = times_q - 1'b1;
                // Once clamped, the true total is unknown, so the sum stays pinned.
                if (!sat_q) begin
                    sum_d = sum_q - W_S'(top);
                end
                if (times_q == W_T'(1)) begin
                    scal_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            times_q  <= '0;
            sum_q    <= '0;
            sat_q    <= 1'b0;
            scal_q   <= 1'b0;
            sres_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            times_q  <= times_d;
            sum_q    <= sum_d;
            sat_q    <= sat_d;
            scal_q   <= scal_d;
            sres_q   <= sres_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (times_q == W_T'(i)) begin
                    stack_q[i] <= prod_q;
                end
            end
        end
    end

    assign bus.price       = top;
    assign bus.times       = times_q;
    assign bus.sum         = sum_q;
    assign bus.state_cal   = scal_q;
    assign bus.state_reset = sres_q;
    assign bus.busy        = (state_q == MUL) || (state_q == ADD);
    assign bus.full        = full;
    assign bus.sat         = sat_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_shop_ledger.sv
// tb/tb_shop_ledger.sv - self-checking bench for shop_ledger (default and narrow-sum instances)
module tb_shop_ledger;
    localparam int W_W = 4, W_P = 4, W_S = 16, DEPTH = 8, W_T = 8, W_SB = 8;
    localparam int MAXA = (1 << W_S) - 1;
    localparam int MAXB = (1 << W_SB) - 1;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    shop_ledger_if #(.W_W(W_W), .W_P(W_P), .W_S(W_S),  .W_T(W_T)) ia();
    shop_ledger_if #(.W_W(W_W), .W_P(W_P), .W_S(W_SB), .W_T(W_T)) ib();

    shop_ledger #(.W_W(W_W), .W_P(W_P), .W_S(W_S), .DEPTH(DEPTH), .W_T(W_T)) dut_a (
        .clk100mhz(clk), .reset(rst_a), .bus(ia));
    shop_ledger #(.W_W(W_W), .W_P(W_P), .W_S(W_SB), .DEPTH(DEPTH), .W_T(W_T)) dut_b (
        .clk100mhz(clk), .reset(rst_b), .bus(ib));

    typedef struct {
        int price, times, sum, scal, sres, busy, full, sat, err;
    } obs_t;

    typedef struct {
        int op, w, p;
        int e_err, e_price, e_sum, e_times, e_full;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference ledger: plain list of item prices plus arithmetic total.
    int  mq[$];
    int  msum;
    bit  msat;

    function automatic obs_t snap(int sel);
        obs_t o;
        if (sel == 0) begin
            o.price = ia.price; o.times = ia.times; o.sum = ia.sum;
            o.scal = ia.state_cal; o.sres = ia.state_reset; o.busy = ia.busy;
            o.full = ia.full; o.sat = ia.sat; o.err = ia.err;
        end else begin
            o.price = ib.price; o.times = ib.times; o.sum = ib.sum;
            o.scal = ib.state_cal; o.sres = ib.state_reset; o.busy = ib.busy;
            o.full = ib.full; o.sat = ib.sat; o.err = ib.err;
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic setin(input int sel, input int c, input int u, input int w, input int p);
        if (sel == 0) begin
            ia.cal = c[0]; ia.undo = u[0]; ia.weight = 4'(w); ia.per = 4'(p);
        end else begin
            ib.cal = c[0]; ib.undo = u[0]; ib.weight = 4'(w); ib.per = 4'(p);
        end
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        if (sel == 0) begin
            mq.delete();
            msum = 0;
            msat = 1'b0;
        end
    endtask

    function automatic int model_op(int op, int w, int p);
        int v;
        if (op == 2) return 1;
        if (op == 0) begin
            if (mq.size() == DEPTH) return 1;
            mq.push_back(w * p);
            msum = msum + w * p;
            if (msum > MAXA) begin
                msum = MAXA;
                msat = 1'b1;
            end
            return 0;
        end
        if (mq.size() == 0) return 1;
        v = mq.pop_back();
        if (!msat) msum = msum - v;
        return 0;
    endfunction

    function automatic int model_price();
        if (mq.size() == 0) return 0;
        return mq[mq.size() - 1];
    endfunction

    // op: 0 = cal, 1 = undo, 2 = both at once. Returns at a falling edge once idle.
    task automatic do_op(input int sel, input int op, input int w, input int p,
                         output int err1, output int err2, output int bcyc);
        obs_t o;
        int   n;
        @(negedge clk);
        setin(sel, (op != 1) ? 1 : 0, (op != 0) ? 1 : 0, w, p);
        @(negedge clk);
        setin(sel, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15));
        o = snap(sel);
        err1 = o.err;
        bcyc = o.busy;
        err2 = -1;
        n = 0;
        while (1) begin
            @(negedge clk);
            o = snap(sel);
            if (err2 < 0) err2 = o.err;
            if (!o.busy) break;
            bcyc++;
            n++;
            if (n > 20) begin
                chk("busy_timeout", o.busy, 0);
                break;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        obs_t o;
        int e1, e2, bc, eerr, op, w, p, r;

        rst_a = 1'b1;
        rst_b = 1'b1;
        setin(0, 0, 0, 0, 0);
        setin(1, 0, 0, 0, 0);

        tbl.push_back('{0, 5, 7,   0, 35, 35, 1, 0});
        tbl.push_back('{0, 3, 4,   0, 12, 47, 2, 0});
        tbl.push_back('{0, 15, 15, 0, 225, 272, 3, 0});
        tbl.push_back('{1, 0, 0,   0, 12, 47, 2, 0});
        tbl.push_back('{1, 0, 0,   0, 35, 35, 1, 0});
        tbl.push_back('{1, 0, 0,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0,   1, 0, 0, 0, 0});
        tbl.push_back('{2, 2, 2,   1, 0, 0, 0, 0});
        for (int k = 1; k <= DEPTH; k++) begin
            tbl.push_back('{0, 1, 1, 0, 1, k, k, (k == DEPTH) ? 1 : 0});
        end
        tbl.push_back('{0, 1, 1,   1, 1, 8, 8, 1});
        tbl.push_back('{0, 9, 9,   1, 1, 8, 8, 1});

        do_reset(0);
        do_reset(1);

        // Reset values
        o = snap(0);
        chk("rst_price", o.price, 0);
        chk("rst_times", o.times, 0);
        chk("rst_sum", o.sum, 0);
        chk("rst_state_cal", o.scal, 0);
        chk("rst_state_reset", o.sres, 1);
        chk("rst_busy", o.busy, 0);
        chk("rst_full", o.full, 0);
        chk("rst_sat", o.sat, 0);
        chk("rst_err", o.err, 0);

        // Add latency: results appear on the 6th edge, busy high for 5 cycles
        @(negedge clk);
        setin(0, 1, 0, 5, 7);
        bc = 0;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            setin(0, 0, 0, 0, 0);
            o = snap(0);
            if (o.busy) bc++;
            if (e == 5) begin
                chk("lat_sum_before", o.sum, 0);
                chk("lat_times_before", o.times, 0);
                chk("lat_sres_before", o.sres, 1);
            end
        end
        o = snap(0);
        chk("lat_price", o.price, 35);
        chk("lat_sum", o.sum, 35);
        chk("lat_times", o.times, 1);
        chk("lat_state_cal", o.scal, 1);
        chk("lat_state_reset", o.sres, 0);
        chk("lat_busy_cycles", bc, 5);
        do_reset(0);

        // Table-driven sequence
        for (int i = 0; i < tbl.size(); i++) begin
            eerr = model_op(tbl[i].op, tbl[i].w, tbl[i].p);
            do_op(0, tbl[i].op, tbl[i].w, tbl[i].p, e1, e2, bc);
            o = snap(0);
            chk($sformatf("tbl%0d_err", i), e1, tbl[i].e_err);
            chk($sformatf("tbl%0d_err_one_cycle", i), e2, 0);
            chk($sformatf("tbl%0d_price", i), o.price, tbl[i].e_price);
            chk($sformatf("tbl%0d_sum", i), o.sum, tbl[i].e_sum);
            chk($sformatf("tbl%0d_times", i), o.times, tbl[i].e_times);
            chk($sformatf("tbl%0d_full", i), o.full, tbl[i].e_full);
            chk($sformatf("tbl%0d_model_sum", i), o.sum, msum);
        end

        // cal during MUL is rejected and only one item lands
        do_reset(0);
        @(negedge clk);
        setin(0, 1, 0, 6, 3);
        @(negedge clk);
        setin(0, 0, 0, 0, 0);
        @(negedge clk);
        setin(0, 1, 0, 2, 2);
        @(negedge clk);
        setin(0, 0, 0, 0, 0);
        chk("mulcal_err", snap(0).err, 1);
        @(negedge clk);
        chk("mulcal_err_clear", snap(0).err, 0);
        repeat (4) @(negedge clk);
        o = snap(0);
        chk("mulcal_times", o.times, 1);
        chk("mulcal_sum", o.sum, 18);
        chk("mulcal_busy", o.busy, 0);

        // Reset during the 2nd MUL cycle aborts the add
        @(negedge clk);
        setin(0, 1, 0, 7, 7);
        @(negedge clk);
        setin(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        o = snap(0);
        chk("abort_busy", o.busy, 0);
        chk("abort_times", o.times, 0);
        chk("abort_sum", o.sum, 0);
        chk("abort_state_reset", o.sres, 1);
        chk("abort_price", o.price, 0);
        mq.delete(); msum = 0; msat = 1'b0;
        eerr = model_op(0, 2, 3);
        do_op(0, 0, 2, 3, e1, e2, bc);
        o = snap(0);
        chk("abort_fresh_sum", o.sum, 6);
        chk("abort_fresh_times", o.times, 1);
        chk("abort_fresh_busy_cycles", bc, 5);

        // Randomised ops against the reference ledger
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 19);
            op = (r < 13) ? 0 : ((r < 19) ? 1 : 2);
            w = $urandom_range(0, 15);
            p = $urandom_range(0, 15);
            eerr = model_op(op, w, p);
            do_op(0, op, w, p, e1, e2, bc);
            o = snap(0);
            chk($sformatf("rnd%0d_err", i), e1, eerr);
            chk($sformatf("rnd%0d_err_one_cycle", i), e2, 0);
            chk($sformatf("rnd%0d_busy_cycles", i), bc, (op == 0 && eerr == 0) ? 5 : 0);
            chk($sformatf("rnd%0d_price", i), o.price, model_price());
            chk($sformatf("rnd%0d_sum", i), o.sum, msum);
            chk($sformatf("rnd%0d_times", i), o.times, mq.size());
            chk($sformatf("rnd%0d_full", i), o.full, (mq.size() == DEPTH) ? 1 : 0);
            chk($sformatf("rnd%0d_state_cal", i), o.scal, (mq.size() > 0) ? 1 : 0);
        end

        // Narrow-sum instance: saturation and sticky sat
        do_op(1, 0, 15, 15, e1, e2, bc);
        o = snap(1);
        chk("b_sum1", o.sum, 225);
        chk("b_sat1", o.sat, 0);
        do_op(1, 0, 15, 15, e1, e2, bc);
        o = snap(1);
        chk("b_sum2", o.sum, MAXB);
        chk("b_sat2", o.sat, 1);
        chk("b_times2", o.times, 2);
        do_op(1, 1, 0, 0, e1, e2, bc);
        o = snap(1);
        chk("b_undo_sum", o.sum, MAXB);
        chk("b_undo_times", o.times, 1);
        chk("b_undo_sat", o.sat, 1);
        chk("b_undo_price", o.price, 225);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        o = snap(1);
        chk("b_rst_sat", o.sat, 0);
        chk("b_rst_sum", o.sum, 0);
        chk("b_rst_times", o.times, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
